// File: rtl/exec_mem_datapath_pkg.sv
// Opcode and mux-select encodings shared between the control unit and the exec/mem datapath.
package exec_mem_datapath_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic SEL1_ALU    = 1'b1;
  localparam logic SEL1_MEM    = 1'b0;
  localparam logic SEL3_OFFSET = 1'b1;
  localparam logic SEL3_ALU    = 1'b0;

endpackage

// File: rtl/exec_mem_datapath_if.sv
// Control-unit <-> datapath bundle: operands/controls in, result2, flags and debug address back.
// No handshake: the control unit holds inputs steady and samples result2 one edge later.
interface exec_mem_datapath_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
);
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] offset;
  logic [3:0]            opcode;
  logic                  sel1;
  logic                  sel3;
  logic                  w_r;
  logic [DATA_WIDTH-1:0] result2;
  logic                  zero_flag;
  logic                  carry_flag;
  logic [ADDR_BITS-1:0]  mem_addr;

  modport master (
    output operand1, operand2, offset, opcode, sel1, sel3, w_r,
    input  result2, zero_flag, carry_flag, mem_addr
  );

  modport slave (
    input  operand1, operand2, offset, opcode, sel1, sel3, w_r,
    output result2, zero_flag, carry_flag, mem_addr
  );
endinterface

// File: rtl/exec_mem_datapath_data_mem_sync.sv
// Synchronous read-first RAM, reset loads word i with i; registered read, 1-cycle latency.
// No backpressure: a read and an optional write complete on every edge.
module data_mem_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic [DATA_WIDTH-1:0] rd_dat
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic [DATA_WIDTH-1:0] ram_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;

  // Read sees ram_q, so a same-edge write to the same address returns the old word.
  always_comb begin
    ram_d = ram_q;
    rd_d  = ram_q[addr];
    if (wr_en) begin
      ram_d[addr] = wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_q[i] <= DATA_WIDTH'(i);
      end
      rd_q <= '0;
    end else begin
      ram_q <= ram_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_dat = rd_q;
endmodule

// File: rtl/exec_mem_datapath.sv
// ALU with registered result/flags, address mux and data memory; result2 valid one edge after inputs.
// No backpressure: inputs are consumed every edge; holding them steady keeps result2 steady.
module exec_mem_datapath
  import exec_mem_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input logic                clk,
  input logic                rst,
  exec_mem_datapath_if.slave dp
);
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_cy;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [ADDR_BITS-1:0]  addr_sum;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd;

  always_comb begin
    sum     = {1'b0, dp.operand1} + {1'b0, dp.operand2};
    diff    = {1'b0, dp.operand1} - {1'b0, dp.operand2};
    alu_res = dp.operand1;
    alu_cy  = 1'b0;
    case (dp.opcode)
      OP_ADD: begin alu_res = sum[DATA_WIDTH-1:0];  alu_cy = sum[DATA_WIDTH];  end
      OP_SUB: begin alu_res = diff[DATA_WIDTH-1:0]; alu_cy = diff[DATA_WIDTH]; end
      OP_AND: alu_res = dp.operand1 & dp.operand2;
      OP_OR:  alu_res = dp.operand1 | dp.operand2;
      OP_XOR: alu_res = dp.operand1 ^ dp.operand2;
      OP_NOT: alu_res = ~dp.operand1;
      OP_SHL: alu_res = dp.operand1 << dp.operand2[2:0];
      OP_SHR: alu_res = dp.operand1 >> dp.operand2[2:0];
      default: alu_res = dp.operand1;
    endcase
  end

  // NOP freezes the registered result and both flags.
  always_comb begin
    alu_d   = alu_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (dp.opcode != OP_NOP) begin
      alu_d   = alu_res;
      zero_d  = (alu_res == '0);
      carry_d = alu_cy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Only the low address bits matter, so the add wraps modulo the memory depth.
  always_comb begin
    addr_sum = dp.operand1[ADDR_BITS-1:0] + dp.offset[ADDR_BITS-1:0];
    mem_addr = (dp.sel3 == SEL3_OFFSET) ? addr_sum : alu_res[ADDR_BITS-1:0];
  end

  data_mem_sync #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_data_mem (
    .clk   (clk),
    .rst   (rst),
    .wr_en (dp.w_r),
    .addr  (mem_addr),
    .wr_dat(dp.operand2),
    .rd_dat(mem_rd)
  );

  assign dp.result2    = (dp.sel1 == SEL1_ALU) ? alu_q : mem_rd;
  assign dp.zero_flag  = zero_q;
  assign dp.carry_flag = carry_q;
  assign dp.mem_addr   = mem_addr;
endmodule

// File: tb/tb_exec_mem_datapath.sv
// Directed scenarios plus random traffic against a plain-arithmetic reference of the datapath.
module tb_exec_mem_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;

  exec_mem_datapath_if #(.DATA_WIDTH(8), .ADDR_BITS(5)) bus ();

  exec_mem_datapath #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk(clk),
    .rst(rst),
    .dp (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  int m_mem [32];
  int m_alu, m_zero, m_carry, m_memq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int alu_calc(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return (a * (1 << (b % 8))) % 256;
      7: return a / (1 << (b % 8));
      default: return a;
    endcase
  endfunction

  function automatic int model_addr();
    int a, b, off;
    a   = int'(bus.operand1);
    b   = int'(bus.operand2);
    off = int'(bus.offset);
    if (bus.sel3) return (a + off) % 32;
    return alu_calc(int'(bus.opcode), a, b) % 32;
  endfunction

  task automatic model_edge();
    int a, b, op, addr;
    a  = int'(bus.operand1);
    b  = int'(bus.operand2);
    op = int'(bus.opcode);
    if (rst) begin
      m_alu = 0; m_zero = 0; m_carry = 0; m_memq = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = i;
    end else begin
      addr   = model_addr();
      m_memq = m_mem[addr];
      if (bus.w_r) m_mem[addr] = b;
      if (op != 15) begin
        m_alu   = alu_calc(op, a, b);
        m_zero  = (m_alu == 0) ? 1 : 0;
        m_carry = (op == 0) ? ((a + b > 255) ? 1 : 0) : (op == 1) ? ((a < b) ? 1 : 0) : 0;
      end
    end
  endtask

  task automatic step(input string tag);
    #1;
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(model_addr()));
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_res"},   32'(bus.result2),    32'(bus.sel1 ? m_alu : m_memq));
    check({tag, "_zero"},  32'(bus.zero_flag),  32'(m_zero));
    check({tag, "_carry"}, 32'(bus.carry_flag), 32'(m_carry));
  endtask

  task automatic drive(input int op1, input int op2, input int off, input int op,
                       input logic s1, input logic s3, input logic wr);
    bus.operand1 = 8'(op1);
    bus.operand2 = 8'(op2);
    bus.offset   = 8'(off);
    bus.opcode   = 4'(op);
    bus.sel1     = s1;
    bus.sel3     = s3;
    bus.w_r      = wr;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step("reset");
    check("reset_alu_zero", 32'(bus.zero_flag), 32'd0);
    rst = 1'b0;

    drive(0, 0, 7, 0, 1'b0, 1'b1, 1'b0);
    step("rd7");
    check("rd7_const", 32'(bus.result2), 32'd7);

    for (int i = 0; i < 32; i++) begin
      drive(i, 0, 0, 15, 1'b0, 1'b1, 1'b0);
      step("init");
      check("init_const", 32'(bus.result2), 32'(i));
    end

    drive(200, 100, 0, 0, 1'b1, 1'b1, 1'b0);
    step("add");
    check("add_const", 32'(bus.result2), 32'd44);
    check("add_carry", 32'(bus.carry_flag), 32'd1);

    drive(5, 5, 0, 1, 1'b1, 1'b1, 1'b0);
    step("sub");
    check("sub_zero", 32'(bus.zero_flag), 32'd1);
    check("sub_carry", 32'(bus.carry_flag), 32'd0);

    drive(3, 8'hA5, 4, 0, 1'b0, 1'b1, 1'b1);
    step("st_wr");
    check("st_readfirst", 32'(bus.result2), 32'h07);
    bus.w_r = 1'b0;
    step("st_rd");
    check("st_newdata", 32'(bus.result2), 32'hA5);

    drive(30, 0, 5, 0, 1'b0, 1'b1, 1'b0);
    #1 check("wrap_addr", 32'(bus.mem_addr), 32'd3);
    step("wrap");
    check("wrap_const", 32'(bus.result2), 32'd3);

    drive(4, 5, 0, 0, 1'b1, 1'b1, 1'b0);
    step("pre_nop");
    for (int k = 0; k < 3; k++) begin
      drive(77 + k, 200, 0, 15, 1'b1, 1'b1, 1'b0);
      step("nop");
      check("nop_hold", 32'(bus.result2), 32'd9);
    end

    drive(200, 100, 0, 0, 1'b1, 1'b1, 1'b0);
    step("carry_set");
    drive(2, 8'hFF, 0, 0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    step("rst_wr");
    check("rst_res", 32'(bus.result2), 32'd0);
    check("rst_carry", 32'(bus.carry_flag), 32'd0);
    rst = 1'b0;
    drive(2, 0, 0, 15, 1'b0, 1'b1, 1'b0);
    step("rst_rd");
    check("rst_nowrite", 32'(bus.result2), 32'd2);

    for (int n = 0; n < 600; n++) begin
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      if (bus.opcode == 4'hF) bus.sel3 = 1'b1;
      if ($urandom_range(0, 7) == 0) bus.operand2 = bus.operand1;
      rst = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
